// File: rtl/image_pkg.sv
// rtl/image_pkg.sv - shared types, widths and helpers for the 2x2 image downscaler
package image_pkg;

    typedef enum logic [0:0] {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } state_t;

    localparam int IMG_WIDTH_DEFAULT  = 640;
    localparam int IMG_HEIGHT_DEFAULT = 480;
    localparam int COL_W_DEFAULT      = $clog2(IMG_WIDTH_DEFAULT);
    localparam int ROW_W_DEFAULT      = $clog2(IMG_HEIGHT_DEFAULT);

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // A line-buffer entry holds a horizontal pair sum, so one bit wider than a pixel.
    function automatic int lb_entry_w(input int data_width);
        return data_width + 1;
    endfunction

endpackage

// File: rtl/image_line_buf.sv
// rtl/image_line_buf.sv - simple dual-port pair-sum line buffer, registered read, no storage reset
module image_line_buf #(
    parameter int DEPTH  = 320,
    parameter int WIDTH  = 9,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // rdata only changes on a read, so it holds across idle cycles.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/image_downscale_2x2.sv
// rtl/image_downscale_2x2.sv - 2x2 block-average downscaler; DOWNSCALE_ROUND_EN selects round-half-up
module image_downscale_2x2
    import image_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_payload,
    input  logic                  in_data_valid,
    input  logic                  in_sof,
    input  logic                  in_eof,
    output logic [DATA_WIDTH-1:0] out_payload,
    output logic                  out_data_valid,
    output logic                  out_sof,
    output logic                  out_eof,
    output logic                  frame_err
);

    localparam int COL_W   = cnt_w(IMG_WIDTH);
    localparam int ROW_W   = cnt_w(IMG_HEIGHT);
    localparam int ADDR_W  = cnt_w(IMG_WIDTH / 2);
    localparam int ENTRY_W = lb_entry_w(DATA_WIDTH);
    localparam int SUM_W   = DATA_WIDTH + 2;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    state_t                state, state_nxt;
    logic [COL_W-1:0]      col, col_nxt, pcol;
    logic [ROW_W-1:0]      row, row_nxt, prow;
    logic [DATA_WIDTH-1:0] prev_pixel;
    logic                  take, is_last, sof_err, eof_err, err, emit;
    logic                  lb_we, lb_re;
    logic [ADDR_W-1:0]     lb_addr;
    logic [ENTRY_W-1:0]    lb_wdata, lb_rdata;
    logic [SUM_W-1:0]      sum;
    logic [DATA_WIDTH-1:0] result;

    image_line_buf #(
        .DEPTH (IMG_WIDTH / 2),
        .WIDTH (ENTRY_W),
        .ADDR_W(ADDR_W)
    ) u_line_buf (
        .clk  (clk),
        .we   (lb_we),
        .waddr(lb_addr),
        .wdata(lb_wdata),
        .re   (lb_re),
        .raddr(lb_addr),
        .rdata(lb_rdata)
    );

    always_comb begin
        take     = in_data_valid && (in_sof || state == ACTIVE);
        // An sof pixel is always processed as (0,0), whatever the counters say.
        pcol     = in_sof ? '0 : col;
        prow     = in_sof ? '0 : row;
        is_last  = (pcol == COL_LAST) && (prow == ROW_LAST);
        sof_err  = in_sof && (state == ACTIVE) && ((col != '0) || (row != '0));
        eof_err  = (in_eof != is_last);
        err      = take && (sof_err || eof_err);
        emit     = take && !err && pcol[0] && prow[0];
        lb_we    = take && pcol[0] && !prow[0];
        lb_re    = take && !pcol[0] && prow[0];
        lb_addr  = ADDR_W'(pcol >> 1);
        lb_wdata = ENTRY_W'(prev_pixel) + ENTRY_W'(in_payload);
        sum      = SUM_W'(prev_pixel) + SUM_W'(in_payload) + SUM_W'(lb_rdata);
`ifdef DOWNSCALE_ROUND_EN
        result   = DATA_WIDTH'((sum + SUM_W'(2)) >> 2);
`else
        result   = DATA_WIDTH'(sum >> 2);
`endif
        state_nxt = state;
        col_nxt   = col;
        row_nxt   = row;
        if (take) begin
            if (eof_err || is_last) begin
                state_nxt = WAIT_SOF;
                col_nxt   = '0;
                row_nxt   = '0;
            end else begin
                state_nxt = ACTIVE;
                if (pcol == COL_LAST) begin
                    col_nxt = '0;
                    row_nxt = prow + ROW_W'(1);
                end else begin
                    col_nxt = pcol + COL_W'(1);
                    row_nxt = prow;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WAIT_SOF;
            col   <= '0;
            row   <= '0;
        end else begin
            state <= state_nxt;
            col   <= col_nxt;
            row   <= row_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_pixel     <= '0;
            out_payload    <= '0;
            out_data_valid <= 1'b0;
            out_sof        <= 1'b0;
            out_eof        <= 1'b0;
            frame_err      <= 1'b0;
        end else begin
            if (take && !pcol[0]) begin
                prev_pixel <= in_payload;
            end
            if (emit) begin
                out_payload <= result;
            end
            out_data_valid <= emit;
            out_sof        <= emit && (pcol == COL_W'(1)) && (prow == ROW_W'(1));
            out_eof        <= emit && is_last;
            frame_err      <= err;
        end
    end

endmodule

// File: doc/image_downscale_2x2.md
Name: image_downscale_2x2

Overview:
- Consumes a raw pixel stream (payload/data_valid/sof/eof bundle) and emits a half-width, half-height stream.
- Each output pixel is the average of one non-overlapping 2x2 input block.
- Sits directly downstream of the image capture/source stage and feeds the display/sink stage.
- The stream has no backpressure; the output rate is at most 1/4 of the input rate.

Parameters:
- DATA_WIDTH, 8, pixel payload width.
- IMG_WIDTH, 640, input pixels per line; must be even and at least 2.
- IMG_HEIGHT, 480, input lines per frame; must be even and at least 2.

Ports:
- clk  input  1  clock for all logic.
- rst  input  1  asynchronous, active-high reset.
- in_payload  input  DATA_WIDTH  input pixel.
- in_data_valid  input  1  input pixel qualifier.
- in_sof  input  1  start of frame; valid only with in_data_valid, marks the first pixel.
- in_eof  input  1  end of frame; valid only with in_data_valid, marks the last pixel.
- out_payload  output  DATA_WIDTH  averaged pixel.
- out_data_valid  output  1  output pixel qualifier, one-cycle pulse per output pixel.
- out_sof  output  1  high with the first output pixel of a frame.
- out_eof  output  1  high with the last output pixel of a frame.
- frame_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset: all outputs are 0, state is WAIT_SOF, col/row counters are 0. Line buffer contents are don't-care.
- Only cycles with in_data_valid=1 advance anything. in_sof/in_eof without in_data_valid are ignored.
- WAIT_SOF:
  - Valid pixels without in_sof are dropped silently.
  - A valid pixel with in_sof is processed as col=0,row=0, and the state moves to ACTIVE.
- ACTIVE: each valid pixel increments col. col wraps to 0 at IMG_WIDTH-1 and row increments.
- Even row, odd col: store (prev_pixel + pixel) into the line buffer at address col>>1. Entry width is DATA_WIDTH+1; no overflow is possible.
- Odd row, even col: issue the line-buffer read at address col>>1. Read latency is 1 cycle.
- Odd row, odd col: sum = prev_pixel + pixel + buffered pair, DATA_WIDTH+2 bits. Result = sum>>2 after optional rounding. Registered output, latency 1 cycle after the accepting input cycle.
- The read data is held until the odd column arrives, even if invalid cycles intervene.
- out_sof is high on output pixel (0,0). out_eof is high on the output pixel produced from input (IMG_WIDTH-1, IMG_HEIGHT-1) when in_eof is also high on that pixel.
- Normal completion: the last pixel (col=IMG_WIDTH-1, row=IMG_HEIGHT-1) arrives with in_eof=1. Emit the final output with out_eof=1 and return to WAIT_SOF.
- Violations: each pulses frame_err for 1 cycle on the cycle after the offending input. The pixel that triggers the error produces no output.
  - in_eof before the last pixel: return to WAIT_SOF, no out_eof.
  - Last pixel without in_eof: return to WAIT_SOF, no out_eof.
  - in_sof while ACTIVE, not on pixel (0,0): restart the counters with this pixel as (0,0) and stay ACTIVE. The partial frame is abandoned with no out_eof.
- Simultaneous in_sof and in_eof on one pixel: treated as sof plus early eof. frame_err pulses and the state returns to WAIT_SOF.
- Reset mid-frame: everything returns to reset values immediately (asynchronous). The next frame requires in_sof.

Optional Feature:
- Macro DOWNSCALE_ROUND_EN.
- Defined: result = (sum + 2) >> 2, round half up, computed in DATA_WIDTH+2 bits. The maximum result 255 cannot overflow.
- Undefined: result = sum >> 2, truncation.

Decomposition:
- Shared package image_pkg holds:
  - the state typedef (WAIT_SOF, ACTIVE);
  - localparams for counter widths via $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT);
  - the line-buffer entry width DATA_WIDTH+1.
- One sub-module, image_line_buf: simple dual-port RAM with IMG_WIDTH/2 entries, synchronous write, registered read (1-cycle latency), no reset on storage.

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=2, rows [10,20,30,40] and [50,60,70,80] with sof/eof on the first/last pixels.
  - Round enabled: outputs 35 (sof) then 55 (eof).
  - Round disabled: same values, since the sums 140 and 220 are exact multiples of 4.
- All-255 frame, 4x2: outputs are 255,255 with no overflow. Block [1,2],[2,2] (sum 7): 2 with round enabled, 1 with round disabled.
- Random invalid-cycle gaps, including between the line-buffer read and the odd column: outputs match the gapless reference bit-for-bit.
- Faults:
  - in_eof on pixel 3 of an 8-pixel frame: frame_err pulse, no out_eof, state back to WAIT_SOF.
  - Pixels before any sof: no output.
- in_sof at pixel 5 of a frame: frame_err pulse, then a full correct frame counted from that pixel with out_sof on its first output.
- Assert rst during odd-row processing: all outputs 0 immediately. The next sof frame is processed correctly.
